// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, FSM states, twiddle tables and bit reversal for the 64-point FFT engines
package fft_pkg;
  localparam int N = 64;
  localparam int LOG2N = 6;
  localparam int DW = 16;
  localparam int TW = 16;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  // Q2.14 twiddles: cos/sin(2*pi*k/64), k = 0..31
  localparam logic signed [TW-1:0] TW_COS [32] = '{
    16'sd16384, 16'sd16305, 16'sd16069, 16'sd15679, 16'sd15137, 16'sd14449, 16'sd13623, 16'sd12665,
    16'sd11585, 16'sd10394, 16'sd9102, 16'sd7723, 16'sd6270, 16'sd4756, 16'sd3196, 16'sd1606,
    16'sd0, -16'sd1606, -16'sd3196, -16'sd4756, -16'sd6270, -16'sd7723, -16'sd9102, -16'sd10394,
    -16'sd11585, -16'sd12665, -16'sd13623, -16'sd14449, -16'sd15137, -16'sd15679, -16'sd16069, -16'sd16305};
  localparam logic signed [TW-1:0] TW_SIN [32] = '{
    16'sd0, 16'sd1606, 16'sd3196, 16'sd4756, 16'sd6270, 16'sd7723, 16'sd9102, 16'sd10394,
    16'sd11585, 16'sd12665, 16'sd13623, 16'sd14449, 16'sd15137, 16'sd15679, 16'sd16069, 16'sd16305,
    16'sd16384, 16'sd16305, 16'sd16069, 16'sd15679, 16'sd15137, 16'sd14449, 16'sd13623, 16'sd12665,
    16'sd11585, 16'sd10394, 16'sd9102, 16'sd7723, 16'sd6270, 16'sd4756, 16'sd3196, 16'sd1606};
  function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] x);
    return {x[0], x[1], x[2], x[3], x[4], x[5]};
  endfunction
endpackage

// File: rtl/ifft_butterfly.sv
// ifft_butterfly: radix-2 DIT butterfly with rounded twiddle multiply, halving and saturation
module ifft_butterfly
  import fft_pkg::*;
(
  input  logic signed [DW-1:0] a_re_i,
  input  logic signed [DW-1:0] a_im_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  input  logic signed [TW-1:0] w_re_i,
  input  logic signed [TW-1:0] w_im_i,
  output logic signed [DW-1:0] top_re_o,
  output logic signed [DW-1:0] top_im_o,
  output logic signed [DW-1:0] bot_re_o,
  output logic signed [DW-1:0] bot_im_o
);
  logic signed [32:0] p_re, p_im;
  logic signed [17:0] t_re, t_im;
  function automatic logic signed [DW-1:0] half_sat(input logic signed [17:0] s);
    logic signed [17:0] h;
    h = s >>> 1;
    return h > 18'sd32767 ? 16'sh7fff : h < -18'sd32768 ? 16'sh8000 : h[15:0];
  endfunction
  always_comb begin
    p_re = 33'(b_re_i) * 33'(w_re_i) - 33'(b_im_i) * 33'(w_im_i);
    p_im = 33'(b_re_i) * 33'(w_im_i) + 33'(b_im_i) * 33'(w_re_i);
    t_re = 18'((p_re + 33'sd8192) >>> 14);
    t_im = 18'((p_im + 33'sd8192) >>> 14);
  end
  assign top_re_o = half_sat(18'(a_re_i) + t_re);
  assign top_im_o = half_sat(18'(a_im_i) + t_im);
  assign bot_re_o = half_sat(18'(a_re_i) - t_re);
  assign bot_im_o = half_sat(18'(a_im_i) - t_im);
endmodule

// File: rtl/ifft64_engine.sv
// ifft64_engine: in-place 64-point radix-2 DIT inverse FFT, one butterfly per falling clock edge
module ifft64_engine
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [DW-1:0] in_re [N],
  input  logic signed [DW-1:0] in_im [N],
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] out_re [N],
  output logic signed [DW-1:0] out_im [N]
);
  state_t state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic [LOG2N-2:0] bfly_q, bfly_d, mask, k;
  logic [LOG2N-1:0] h, top_a, bot_a;
  logic signed [DW-1:0] re_q [N];
  logic signed [DW-1:0] im_q [N];
  logic signed [DW-1:0] top_re, top_im, bot_re, bot_im;
  logic last, fin;
  always_comb begin
    h = 6'd1 << stage_q;
    mask = 5'(h - 6'd1);
    top_a = {bfly_q & ~mask, 1'b0} | {1'b0, bfly_q & mask};
    bot_a = top_a | h;
    k = (bfly_q & mask) << (3'd5 - stage_q);
    last = &bfly_q;
    fin = last && stage_q == 3'd5;
    state_d = state_q == IDLE ? (start ? CALC : IDLE) : state_q == CALC ? (fin ? DONE : CALC) : IDLE;
    stage_d = (state_q == CALC && !fin) ? stage_q + 3'(last) : '0;
    bfly_d = state_q == CALC ? bfly_q + 5'd1 : '0;
  end
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      bfly_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q <= bfly_d;
    end
  end
  ifft_butterfly u_bfly (
    .a_re_i(re_q[top_a]), .a_im_i(im_q[top_a]),
    .b_re_i(re_q[bot_a]), .b_im_i(im_q[bot_a]),
    .w_re_i(TW_COS[k]), .w_im_i(TW_SIN[k]),
    .top_re_o(top_re), .top_im_o(top_im),
    .bot_re_o(bot_re), .bot_im_o(bot_im)
  );
  // Inputs land bit-reversed so the DIT stages produce natural-order time samples
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (state_q == IDLE && start) begin
      for (int i = 0; i < N; i++) begin
        re_q[bitrev6(6'(i))] <= in_re[i];
        im_q[bitrev6(6'(i))] <= in_im[i];
      end
    end else if (state_q == CALC) begin
      re_q[top_a] <= top_re;
      im_q[top_a] <= top_im;
      re_q[bot_a] <= bot_re;
      im_q[bot_a] <= bot_im;
    end
  end
  assign busy = state_q == CALC;
  assign done = state_q == DONE;
  assign out_re = re_q;
  assign out_im = im_q;
endmodule

// File: tb/tb_ifft64_engine.sv
// tb_ifft64_engine: scoreboard bench for ifft64_engine against a floating-point inverse DFT
module tb_ifft64_engine;
  localparam real PI = 3.14159265358979;
  typedef struct { int n; bit im; int val; int tol; } exp_t;
  logic clk = 0, rst = 0, start = 0;
  logic busy, done;
  logic signed [15:0] in_re [64];
  logic signed [15:0] in_im [64];
  logic signed [15:0] out_re [64];
  logic signed [15:0] out_im [64];
  exp_t sb[$];
  int total = 0, passed = 0;

  ifft64_engine dut (
    .clk(clk), .rst(rst), .start(start), .in_re(in_re), .in_im(in_im),
    .busy(busy), .done(done), .out_re(out_re), .out_im(out_im)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void clear_in();
    for (int i = 0; i < 64; i++) begin
      in_re[i] = 0;
      in_im[i] = 0;
    end
  endfunction

  function automatic void push_exp(int n, bit im, int val, int tol);
    exp_t e;
    e.n = n; e.im = im; e.val = val; e.tol = tol;
    sb.push_back(e);
  endfunction

  // Reference: x[n] = (1/64) sum X[k] e^{+j 2 pi k n / 64}
  function automatic void push_model(int tol);
    real sr, si, th;
    for (int n = 0; n < 64; n++) begin
      sr = 0.0;
      si = 0.0;
      for (int k = 0; k < 64; k++) begin
        th = 2.0 * PI * real'(k * n) / 64.0;
        sr += real'(in_re[k]) * $cos(th) - real'(in_im[k]) * $sin(th);
        si += real'(in_re[k]) * $sin(th) + real'(in_im[k]) * $cos(th);
      end
      push_exp(n, 0, int'(sr / 64.0), tol);
      push_exp(n, 1, int'(si / 64.0), tol);
    end
  endfunction

  // Pulses start, optionally re-pulses it at busy cycle restart_at, scrambles inputs after acceptance
  task automatic run_xform(input int restart_at, output int busy_cyc, output int done_cyc, output bit ok);
    bit seen;
    seen = 0;
    busy_cyc = 0;
    done_cyc = 0;
    @(posedge clk);
    start = 1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      start = (c == restart_at);
      if (c == 0)
        for (int i = 0; i < 64; i++) begin
          in_re[i] = 16'($urandom);
          in_im[i] = 16'($urandom);
        end
      busy_cyc += int'(busy);
      done_cyc += int'(done);
      seen |= done;
      if (seen && !done) break;
    end
    start = 0;
    ok = seen;
  endtask

  task automatic test_reset();
    int nz;
    nz = 0;
    for (int i = 0; i < 64; i++) nz += int'(out_re[i] != 0) + int'(out_im[i] != 0);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (nz !== 0) $display("FAIL reset_outputs: got %0d nonzero want 0", nz); else passed++;
  endtask

  task automatic test_bin0();
    int b, d, act;
    bit ok;
    exp_t e;
    clear_in();
    in_re[0] = 32767;
    for (int n = 0; n < 64; n++) begin
      push_exp(n, 0, 511, 0);
      push_exp(n, 1, 0, 0);
    end
    run_xform(-1, b, d, ok);
    total++; if (ok !== 1'b1) $display("FAIL bin0_done: got %b want 1", ok); else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.im ? int'(out_im[e.n]) : int'(out_re[e.n]);
      total++;
      if (act < e.val - e.tol || act > e.val + e.tol)
        $display("FAIL bin0 %s[%0d]: got %0d want %0d+-%0d", e.im ? "im" : "re", e.n, act, e.val, e.tol);
      else passed++;
    end
  endtask

  task automatic test_flat();
    int b, d, act;
    bit ok;
    exp_t e;
    clear_in();
    for (int i = 0; i < 64; i++) in_re[i] = 1024;
    for (int n = 0; n < 64; n++) begin
      push_exp(n, 0, n == 0 ? 1024 : 0, n == 0 ? 0 : 2);
      push_exp(n, 1, 0, 2);
    end
    run_xform(-1, b, d, ok);
    total++; if (ok !== 1'b1) $display("FAIL flat_done: got %b want 1", ok); else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.im ? int'(out_im[e.n]) : int'(out_re[e.n]);
      total++;
      if (act < e.val - e.tol || act > e.val + e.tol)
        $display("FAIL flat %s[%0d]: got %0d want %0d+-%0d", e.im ? "im" : "re", e.n, act, e.val, e.tol);
      else passed++;
    end
  endtask

  task automatic test_bin1();
    int b, d, act;
    bit ok;
    exp_t e;
    clear_in();
    in_re[1] = 16384;
    push_model(2);
    run_xform(-1, b, d, ok);
    total++; if (ok !== 1'b1) $display("FAIL bin1_done: got %b want 1", ok); else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.im ? int'(out_im[e.n]) : int'(out_re[e.n]);
      total++;
      if (act < e.val - e.tol || act > e.val + e.tol)
        $display("FAIL bin1 %s[%0d]: got %0d want %0d+-%0d", e.im ? "im" : "re", e.n, act, e.val, e.tol);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    int b, d, act;
    bit ok;
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      in_re[i] = 32767;
      in_im[i] = 32767;
    end
    for (int n = 0; n < 64; n++) begin
      push_exp(n, 0, n == 0 ? 32767 : 0, n == 0 ? 0 : 2);
      push_exp(n, 1, n == 0 ? 32767 : 0, n == 0 ? 0 : 2);
    end
    run_xform(-1, b, d, ok);
    total++; if (ok !== 1'b1) $display("FAIL sat_done: got %b want 1", ok); else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.im ? int'(out_im[e.n]) : int'(out_re[e.n]);
      total++;
      if (act < e.val - e.tol || act > e.val + e.tol)
        $display("FAIL sat %s[%0d]: got %0d want %0d+-%0d", e.im ? "im" : "re", e.n, act, e.val, e.tol);
      else passed++;
    end
  endtask

  task automatic test_handshake();
    int b, d, extra;
    bit ok;
    extra = 0;
    clear_in();
    in_re[0] = 32767;
    run_xform(50, b, d, ok);
    total++; if (ok !== 1'b1) $display("FAIL hs_done_seen: got %b want 1", ok); else passed++;
    total++; if (b !== 192) $display("FAIL hs_busy_cycles: got %0d want 192", b); else passed++;
    total++; if (d !== 1) $display("FAIL hs_done_cycles: got %0d want 1", d); else passed++;
    repeat (30) begin
      @(posedge clk);
      extra += int'(done);
    end
    total++; if (extra !== 0) $display("FAIL hs_second_done: got %0d want 0", extra); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL hs_no_restart: got busy %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int b, d, act;
    bit ok;
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 64; i++) begin
        in_re[i] = 16'(int'($urandom_range(0, 16000)) - 8000);
        in_im[i] = 16'(int'($urandom_range(0, 16000)) - 8000);
      end
      push_model(6);
      run_xform(-1, b, d, ok);
      total++; if (ok !== 1'b1) $display("FAIL b2b_done run %0d: got %b want 1", r, ok); else passed++;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = e.im ? int'(out_im[e.n]) : int'(out_re[e.n]);
        total++;
        if (act < e.val - e.tol || act > e.val + e.tol)
          $display("FAIL b2b run %0d %s[%0d]: got %0d want %0d+-%0d", r, e.im ? "im" : "re", e.n, act, e.val, e.tol);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_abort();
    int dn, nz;
    dn = 0;
    nz = 0;
    clear_in();
    in_re[1] = 16384;
    @(posedge clk);
    start = 1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      start = 0;
      dn += int'(done);
    end
    total++; if (busy !== 1'b1) $display("FAIL abort_pre_busy: got %b want 1", busy); else passed++;
    rst = 0;
    #1;
    for (int i = 0; i < 64; i++) nz += int'(out_re[i] != 0) + int'(out_im[i] != 0);
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else passed++;
    total++; if (nz !== 0) $display("FAIL abort_outputs: got %0d nonzero want 0", nz); else passed++;
    total++; if (dn !== 0) $display("FAIL abort_early_done: got %0d want 0", dn); else passed++;
    @(posedge clk);
    rst = 1;
    test_bin0();
  endtask

  initial begin
    clear_in();
    repeat (3) @(posedge clk);
    test_reset();
    rst = 1;
    test_bin0();
    test_flat();
    test_bin1();
    test_saturation();
    test_handshake();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
